// File: rtl/crypt_pkg.sv
// crypt_pkg
//   Shared types and constants for the crypto front-end message packer.
//   Contents:
//     state_t        packer sequencing states
//     SHA_BLK_BYTES  bytes in one SHA-256/224 message block
//     SHA_LEN_POS    block offset where the 64-bit bit-length field starts
//     SHA_PAD_BYTE   first padding byte that follows the message
//     WORD_BYTES     bytes per output word
package crypt_pkg;

  typedef enum logic [2:0] {
    S_DATA,
    S_PAD80,
    S_ZERO,
    S_LEN,
    S_FLUSH
  } state_t;

  localparam int         SHA_BLK_BYTES = 64;
  localparam int         SHA_LEN_POS   = 56;
  localparam logic [7:0] SHA_PAD_BYTE  = 8'h80;
  localparam int         WORD_BYTES    = 4;

endpackage

// File: rtl/crypt_word_reg.sv
// crypt_word_reg
//   One-entry output register for the message packer. Holds a word and its
//   flags stable while the downstream stalls; a load always wins over the
//   clear that would otherwise follow an accepted beat.
// Ports:
//   clk, n_rst      clock (rising edge), async active-low reset
//   load            capture load_* this edge
//   load_data       32-bit word to present
//   load_last       word is the last of its message
//   load_blk_end    word closes a 512-bit block
//   out_ready       downstream accepts the presented word
//   out_valid       word register occupied
//   out_data        presented word (zero when empty)
//   out_last        presented word ends its message
//   out_blk_end     presented word ends a block
module crypt_word_reg (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic        load_blk_end,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        out_blk_end
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_blk_end <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data    <= load_data;
      out_last    <= load_last;
      out_blk_end <= load_blk_end;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_blk_end <= 1'b0;
    end
  end

endmodule

// File: rtl/crypt_msg_packer.sv
// crypt_msg_packer
//   Packs a byte stream into big-endian 32-bit words for the crypto core's
//   input queue. With CRYPT_SHA_PAD_EN defined, SHA-256/224 padding (0x80,
//   zeros, 64-bit bit length) is appended so whole 512-bit blocks are
//   emitted; otherwise a trailing partial word is zero-filled and flagged.
// Parameters:
//   LEN_W        width of the message byte counter
// Ports:
//   clk, n_rst   clock (rising edge), async active-low reset
//   in_valid     in_data/in_last valid
//   in_ready     byte accepted this cycle
//   in_data      message byte, first byte lands in out_data[31:24]
//   in_last      final byte of message
//   out_valid    out_data valid
//   out_ready    downstream accepts word
//   out_data     packed word
//   out_last     final word of message
//   out_blk_end  word closes a 512-bit block (pad build only, else 0)
//   len_ovf      sticky: byte offered with the counter saturated
// Configuration macro: CRYPT_SHA_PAD_EN
module crypt_msg_packer
  import crypt_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        out_blk_end,
  output logic        len_ovf
);

  localparam logic [1:0]       LAST_IDX = 2'(WORD_BYTES - 1);
  localparam logic [LEN_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nxt;
  logic             active;
  logic [1:0]       idx;
  logic [23:0]      acc;
  logic [LEN_W-1:0] cnt;

  logic             word_free, slot_free;
  logic             byte_go, byte_msg, ovf_set;
  logic [7:0]       byte_val;
  logic             word_load, word_last, word_blk_end;
  logic [31:0]      word_data;

`ifdef CRYPT_SHA_PAD_EN
  localparam logic [5:0] PRE_LEN_POS = 6'(SHA_LEN_POS - 1);
  localparam logic [5:0] BLK_LAST    = 6'(SHA_BLK_BYTES - 1);

  logic [5:0]  pos;
  logic [63:0] bit_len, len_sh;

  assign bit_len = 64'(cnt) << 3;
  // Length bytes go out MSB first; pos 56..63 selects byte 0..7.
  assign len_sh  = bit_len << {pos[2:0], 3'b000};
`endif

  // A byte may only complete a word if the output register is free by the
  // same edge; bytes 0..2 of a word only touch the accumulator.
  assign word_free = !out_valid || out_ready;
  assign slot_free = (idx != LAST_IDX) || word_free;
  assign word_data = {acc, byte_val};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_DATA;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    byte_go      = 1'b0;
    byte_msg     = 1'b0;
    byte_val     = in_data;
    word_load    = 1'b0;
    word_last    = 1'b0;
    word_blk_end = 1'b0;
    ovf_set      = 1'b0;

    case (state)
      S_DATA: begin
        in_ready = active && slot_free && !len_ovf;
        // A byte offered at the saturated count is dropped, not packed.
        if (in_valid && in_ready && (cnt == CNT_MAX)) begin
          ovf_set = 1'b1;
        end else if (in_valid && in_ready) begin
          byte_go  = 1'b1;
          byte_msg = 1'b1;
          if (in_last) begin
`ifdef CRYPT_SHA_PAD_EN
            state_nxt = S_PAD80;
`else
            if (idx == LAST_IDX) begin
              word_last = 1'b1;
            end else begin
              state_nxt = S_FLUSH;
            end
`endif
          end
        end
      end
`ifdef CRYPT_SHA_PAD_EN
      S_PAD80: begin
        if (slot_free) begin
          byte_go   = 1'b1;
          byte_val  = SHA_PAD_BYTE;
          state_nxt = (pos == PRE_LEN_POS) ? S_LEN : S_ZERO;
        end
      end
      S_ZERO: begin
        if (slot_free) begin
          byte_go  = 1'b1;
          byte_val = 8'h00;
          if (pos == PRE_LEN_POS) begin
            state_nxt = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (slot_free) begin
          byte_go  = 1'b1;
          byte_val = len_sh[63:56];
          if (pos == BLK_LAST) begin
            word_last = 1'b1;
            state_nxt = S_DATA;
          end
        end
      end
`else
      S_FLUSH: begin
        // Unwritten accumulator lanes are already zero.
        if (word_free) begin
          byte_val  = 8'h00;
          word_load = 1'b1;
          word_last = 1'b1;
          state_nxt = S_DATA;
        end
      end
`endif
      default: state_nxt = S_DATA;
    endcase

    if (byte_go && (idx == LAST_IDX)) begin
      word_load = 1'b1;
    end
`ifdef CRYPT_SHA_PAD_EN
    word_blk_end = byte_go && (pos == BLK_LAST);
`endif
  end

  // Byte index, accumulator and counters; everything restarts once the
  // message's final word is handed to the output register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      active  <= 1'b0;
      idx     <= '0;
      acc     <= '0;
      cnt     <= '0;
      len_ovf <= 1'b0;
`ifdef CRYPT_SHA_PAD_EN
      pos     <= '0;
`endif
    end else begin
      active <= 1'b1;
      if (ovf_set) begin
        len_ovf <= 1'b1;
      end
      if (word_load && word_last) begin
        idx <= '0;
        acc <= '0;
        cnt <= '0;
`ifdef CRYPT_SHA_PAD_EN
        pos <= '0;
`endif
      end else if (byte_go) begin
        idx <= idx + 2'd1;
`ifdef CRYPT_SHA_PAD_EN
        pos <= pos + 6'd1;
`endif
        if (byte_msg) begin
          cnt <= cnt + LEN_W'(1);
        end
        case (idx)
          2'd0:    acc[23:16] <= byte_val;
          2'd1:    acc[15:8]  <= byte_val;
          2'd2:    acc[7:0]   <= byte_val;
          default: acc        <= '0;
        endcase
      end
    end
  end

  crypt_word_reg u_word_reg (
    .clk          (clk),
    .n_rst        (n_rst),
    .load         (word_load),
    .load_data    (word_data),
    .load_last    (word_last),
    .load_blk_end (word_blk_end),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_blk_end  (out_blk_end)
  );

endmodule
